// File: rtl/crosshair_ctl.sv
`default_nettype none
// ============================================================================
// Module   : crosshair_ctl
// Brief    : Light-gun crosshair control: clamps and frame-latches the pointer
//            position, synchronizes the trigger and sequences shot/flash/cooldown.
//            Optional macro CROSSHAIR_SMOOTH_EN enables first-order smoothing.
// Revision : 1.0 - initial release
// ============================================================================
module crosshair_ctl #(
    parameter int H_MAX           = 799,
    parameter int V_MAX           = 599,
    parameter int FLASH_FRAMES    = 3,
    parameter int COOLDOWN_FRAMES = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] xpos_in,
    input  logic [11:0] ypos_in,
    input  logic        pos_valid,
    input  logic        trigger,
    input  logic        vblnk,
    input  logic        gun_is_connected,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        hide,
    output logic        shot,
    output logic [11:0] shot_x,
    output logic [11:0] shot_y,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLASH    = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    localparam logic [11:0] c_h_max      = 12'(H_MAX);
    localparam logic [11:0] c_v_max      = 12'(V_MAX);
    localparam logic [3:0]  c_flash_last = 4'(FLASH_FRAMES - 1);
    localparam logic [3:0]  c_cool_last  = 4'((COOLDOWN_FRAMES > 0) ? COOLDOWN_FRAMES - 1 : 0);
    localparam logic        c_no_cool    = (COOLDOWN_FRAMES == 0);

    state_t      r_state_q,   w_state_d;
    logic [3:0]  r_cnt_q,     w_cnt_d;
    logic        r_vblnk_q,   w_vblnk_d;
    logic        r_sync1_q,   w_sync1_d;
    logic        r_sync2_q,   w_sync2_d;
    logic        r_prev_q,    w_prev_d;
    logic [1:0]  r_vld_q,     w_vld_d;
    logic        r_armed_q,   w_armed_d;
    logic [11:0] r_pend_x_q,  w_pend_x_d;
    logic [11:0] r_pend_y_q,  w_pend_y_d;
    logic [11:0] r_xpos_q,    w_xpos_d;
    logic [11:0] r_ypos_q,    w_ypos_d;
    logic [11:0] r_shot_x_q,  w_shot_x_d;
    logic [11:0] r_shot_y_q,  w_shot_y_d;
    logic        r_shot_q,    w_shot_d;
    logic        r_hide_q,    w_hide_d;
    logic        r_busy_q,    w_busy_d;

    logic        w_frame_tick;
    logic        w_trig_edge;
`ifdef CROSSHAIR_SMOOTH_EN
    logic [12:0] w_sum_x;
    logic [12:0] w_sum_y;
`endif

    assign w_frame_tick = vblnk & ~r_vblnk_q;
    // Edges only count once the synchronized trigger has been seen low after
    // reset, so a trigger held through reset release never fires.
    assign w_trig_edge  = r_sync2_q & ~r_prev_q & r_armed_q;

    always_comb begin
        w_vblnk_d  = vblnk;
        w_sync1_d  = trigger;
        w_sync2_d  = r_sync1_q;
        w_prev_d   = r_sync2_q;
        w_vld_d    = {r_vld_q[0], 1'b1};
        w_armed_d  = r_armed_q | (r_vld_q[1] & ~r_sync2_q);

        w_pend_x_d = r_pend_x_q;
        w_pend_y_d = r_pend_y_q;
        if (pos_valid) begin
            w_pend_x_d = (xpos_in > c_h_max) ? c_h_max : xpos_in;
            w_pend_y_d = (ypos_in > c_v_max) ? c_v_max : ypos_in;
        end

`ifdef CROSSHAIR_SMOOTH_EN
        w_sum_x = {1'b0, r_xpos_q} + {1'b0, r_pend_x_q};
        w_sum_y = {1'b0, r_ypos_q} + {1'b0, r_pend_y_q};
`endif
        w_xpos_d = r_xpos_q;
        w_ypos_d = r_ypos_q;
        if (w_frame_tick) begin
`ifdef CROSSHAIR_SMOOTH_EN
            w_xpos_d = w_sum_x[12:1];
            w_ypos_d = w_sum_y[12:1];
`else
            w_xpos_d = r_pend_x_q;
            w_ypos_d = r_pend_y_q;
`endif
        end
    end

    always_comb begin
        w_state_d  = r_state_q;
        w_cnt_d    = r_cnt_q;
        w_shot_d   = 1'b0;
        w_shot_x_d = r_shot_x_q;
        w_shot_y_d = r_shot_y_q;
        case (r_state_q)
            IDLE: begin
                if (w_trig_edge) begin
                    w_state_d  = FLASH;
                    w_cnt_d    = 4'd0;
                    w_shot_d   = 1'b1;
                    w_shot_x_d = r_xpos_q;
                    w_shot_y_d = r_ypos_q;
                end
            end
            FLASH: begin
                if (w_frame_tick) begin
                    if (r_cnt_q == c_flash_last) begin
                        w_state_d = c_no_cool ? IDLE : COOLDOWN;
                        w_cnt_d   = 4'd0;
                    end else begin
                        w_cnt_d = r_cnt_q + 4'd1;
                    end
                end
            end
            COOLDOWN: begin
                if (w_frame_tick) begin
                    if (r_cnt_q == c_cool_last) begin
                        w_state_d = IDLE;
                        w_cnt_d   = 4'd0;
                    end else begin
                        w_cnt_d = r_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                w_state_d = IDLE;
                w_cnt_d   = 4'd0;
            end
        endcase
        w_busy_d = (w_state_d != IDLE);
        w_hide_d = gun_is_connected | (r_state_q == FLASH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= IDLE;
            r_cnt_q    <= 4'd0;
            r_vblnk_q  <= 1'b0;
            r_sync1_q  <= 1'b0;
            r_sync2_q  <= 1'b0;
            r_prev_q   <= 1'b0;
            r_vld_q    <= 2'b00;
            r_armed_q  <= 1'b0;
            r_pend_x_q <= 12'd0;
            r_pend_y_q <= 12'd0;
            r_xpos_q   <= 12'd0;
            r_ypos_q   <= 12'd0;
            r_shot_x_q <= 12'd0;
            r_shot_y_q <= 12'd0;
            r_shot_q   <= 1'b0;
            r_hide_q   <= 1'b0;
            r_busy_q   <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_cnt_q    <= w_cnt_d;
            r_vblnk_q  <= w_vblnk_d;
            r_sync1_q  <= w_sync1_d;
            r_sync2_q  <= w_sync2_d;
            r_prev_q   <= w_prev_d;
            r_vld_q    <= w_vld_d;
            r_armed_q  <= w_armed_d;
            r_pend_x_q <= w_pend_x_d;
            r_pend_y_q <= w_pend_y_d;
            r_xpos_q   <= w_xpos_d;
            r_ypos_q   <= w_ypos_d;
            r_shot_x_q <= w_shot_x_d;
            r_shot_y_q <= w_shot_y_d;
            r_shot_q   <= w_shot_d;
            r_hide_q   <= w_hide_d;
            r_busy_q   <= w_busy_d;
        end
    end

    assign xpos   = r_xpos_q;
    assign ypos   = r_ypos_q;
    assign shot_x = r_shot_x_q;
    assign shot_y = r_shot_y_q;
    assign shot   = r_shot_q;
    assign hide   = r_hide_q;
    assign busy   = r_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_crosshair_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_crosshair_ctl
// Brief    : Directed self-checking bench for crosshair_ctl with a shot scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_crosshair_ctl;

    localparam int c_h_max = 799;
    localparam int c_v_max = 599;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] xpos_in = 12'd0;
    logic [11:0] ypos_in = 12'd0;
    logic        pos_valid = 1'b0;
    logic        trigger = 1'b0;
    logic        vblnk = 1'b0;
    logic        gun_is_connected = 1'b0;
    logic [11:0] xpos, ypos, shot_x, shot_y;
    logic        hide, shot, busy;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
    } shot_t;

    shot_t       exp_q[$];
    shot_t       mon_e;
    logic        shot_prev = 1'b0;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [11:0] m_x = 0, m_y = 0, m_px = 0, m_py = 0;

    crosshair_ctl dut (
        .clk(clk), .rst(rst), .xpos_in(xpos_in), .ypos_in(ypos_in),
        .pos_valid(pos_valid), .trigger(trigger), .vblnk(vblnk),
        .gun_is_connected(gun_is_connected), .xpos(xpos), .ypos(ypos),
        .hide(hide), .shot(shot), .shot_x(shot_x), .shot_y(shot_y), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] clampv(input logic [11:0] v, input int mx);
        return (int'(v) > mx) ? 12'(mx) : v;
    endfunction

    function automatic logic [11:0] upd(input logic [11:0] cur, input logic [11:0] pend);
`ifdef CROSSHAIR_SMOOTH_EN
        logic [12:0] s;
        s = {1'b0, cur} + {1'b0, pend};
        return s[12:1];
`else
        return pend;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_pos(input logic [11:0] x, input logic [11:0] y);
        xpos_in = x; ypos_in = y; pos_valid = 1'b1;
        tick(1);
        pos_valid = 1'b0;
        m_px = clampv(x, c_h_max);
        m_py = clampv(y, c_v_max);
    endtask

    task automatic vsync();
        vblnk = 1'b1;
        tick(1);
        vblnk = 1'b0;
        m_x = upd(m_x, m_px);
        m_y = upd(m_y, m_py);
        tick(1);
    endtask

    task automatic pulse();
        trigger = 1'b1; tick(3);
        trigger = 1'b0; tick(3);
    endtask

    // Fire from IDLE; shot must appear exactly after the third edge.
    task automatic fire(input int hold);
        exp_q.push_back({m_x, m_y});
        trigger = 1'b1;
        tick(2); check("shot_early", 32'(shot), 0);
        tick(1); check("shot_strobe", 32'(shot), 1); check("busy_at_shot", 32'(busy), 1);
        tick(1); check("shot_width", 32'(shot), 0); check("hide_after_shot", 32'(hide), 1);
        tick(hold);
        trigger = 1'b0;
        tick(3);
    endtask

    // Scoreboard: every shot strobe must match a queued expectation.
    always @(negedge clk) begin
        if (shot) begin
            check("shot_expected", 32'(exp_q.size() > 0), 1);
            check("shot_single_cycle", 32'(shot_prev), 0);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("shot_x", 32'(shot_x), 32'(mon_e.x));
                check("shot_y", 32'(shot_y), 32'(mon_e.y));
            end
        end
        shot_prev = shot;
    end

    initial begin
        tick(3);
        check("rst_xpos", 32'(xpos), 0);
        check("rst_ypos", 32'(ypos), 0);
        check("rst_shot", 32'(shot), 0);
        check("rst_hide", 32'(hide), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_shot_x", 32'(shot_x), 0);
        rst = 1'b0;
        tick(4);

        // clamp
        set_pos(12'd900, 12'd700);
        vsync();
        check("clamp_x", 32'(xpos), 32'(m_x));
        check("clamp_y", 32'(ypos), 32'(m_y));
`ifndef CROSSHAIR_SMOOTH_EN
        check("clamp_x_const", 32'(xpos), 799);
        check("clamp_y_const", 32'(ypos), 599);
`endif
        set_pos(12'd4095, 12'd599);
        vsync();
        check("clamp_max_x", 32'(xpos), 32'(m_x));
        check("clamp_edge_y", 32'(ypos), 32'(m_y));

        // frame-stable update
        set_pos(12'd100, 12'd50);
        check("stable_1", 32'(xpos), 32'(m_x));
        set_pos(12'd200, 12'd60);
        tick(3);
        check("stable_2", 32'(xpos), 32'(m_x));
        vsync();
        check("frame_x", 32'(xpos), 32'(m_x));
        check("frame_y", 32'(ypos), 32'(m_y));

        // sample coinciding with frame tick lands one frame later
        xpos_in = 12'd555; ypos_in = 12'd444; pos_valid = 1'b1; vblnk = 1'b1;
        tick(1);
        pos_valid = 1'b0; vblnk = 1'b0;
        m_x = upd(m_x, m_px); m_y = upd(m_y, m_py);
        m_px = 12'd555; m_py = 12'd444;
        check("coincide_old", 32'(xpos), 32'(m_x));
        tick(1);
        vsync();
        check("coincide_new_x", 32'(xpos), 32'(m_x));
        check("coincide_new_y", 32'(ypos), 32'(m_y));

        // shot with held trigger, then lockout
        set_pos(12'd320, 12'd240);
        vsync(); vsync(); vsync(); vsync();
        fire(5);
        for (int f = 1; f <= 13; f++) begin
            if (f == 2 || f == 6) pulse();
            vsync();
            check("lock_busy", 32'(busy), (f < 13) ? 1 : 0);
            if (f <= 2) check("flash_hide", 32'(hide), 1);
            if (f == 3) check("flash_end_hide", 32'(hide), 0);
        end
        fire(0);
        for (int f = 1; f <= 13; f++) vsync();
        check("idle_again", 32'(busy), 0);

        // frame tick on the shot cycle is not counted
        exp_q.push_back({m_x, m_y});
        trigger = 1'b1;
        tick(2);
        vblnk = 1'b1;
        tick(1);
        m_x = upd(m_x, m_px); m_y = upd(m_y, m_py);
        check("coincide_shot", 32'(shot), 1);
        vblnk = 1'b0;
        tick(1);
        trigger = 1'b0;
        vsync(); vsync();
        check("uncounted_tick", 32'(hide), 1);
        vsync();
        check("flash_done", 32'(hide), 0);
        for (int f = 1; f <= 9; f++) vsync();
        check("cool_9", 32'(busy), 1);
        vsync();
        check("cool_done", 32'(busy), 0);

        // reset mid-FLASH with trigger held
        fire(0);
        trigger = 1'b1;
        vsync();
        rst = 1'b1;
        tick(2);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_hide", 32'(hide), 0);
        check("mid_rst_xpos", 32'(xpos), 0);
        check("mid_rst_shot_x", 32'(shot_x), 0);
        m_x = 0; m_y = 0; m_px = 0; m_py = 0;
        rst = 1'b0;
        tick(12);
        check("held_no_shot_busy", 32'(busy), 0);
        trigger = 1'b0;
        tick(3);
        fire(0);
        check("post_rst_shot_x", 32'(shot_x), 0);
        for (int f = 1; f <= 13; f++) vsync();

        // gun mode forces hide
        gun_is_connected = 1'b1;
        tick(2);
        check("gun_hide", 32'(hide), 1);
        gun_is_connected = 1'b0;
        tick(2);
        check("gun_hide_off", 32'(hide), 0);

`ifdef CROSSHAIR_SMOOTH_EN
        set_pos(12'd400, 12'd0);
        vsync();
        check("smooth_1", 32'(xpos), 200);
        vsync();
        check("smooth_2", 32'(xpos), 300);
`endif

        tick(2);
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/crosshair_ctl.md
CROSSHAIR_CTL -- requirements
Module: crosshair_ctl

Interface
REQ-001 The block SHALL have parameter H_MAX, default 799, meaning the largest legal crosshair x coordinate.
REQ-002 The block SHALL have parameter V_MAX, default 599, meaning the largest legal crosshair y coordinate.
REQ-003 The block SHALL have parameter FLASH_FRAMES, default 3, meaning the number of frames the crosshair is hidden after a shot (legal range 1..15).
REQ-004 The block SHALL have parameter COOLDOWN_FRAMES, default 10, meaning the number of frames triggers are ignored after the flash (legal range 0..15).
REQ-005 The block SHALL have the following ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- xpos_in  in  12  raw pointer x from the gun/mouse
- ypos_in  in  12  raw pointer y
- pos_valid  in  1  xpos_in/ypos_in valid this cycle
- trigger  in  1  asynchronous gun trigger, high when pulled
- vblnk  in  1  vertical blank from the VGA timing chain
- gun_is_connected  in  1  gun mode active
- xpos  out  12  frame-stable crosshair x for the overlay stage
- ypos  out  12  frame-stable crosshair y
- hide  out  1  suppress crosshair; drives the overlay stage's gun_is_connected input
- shot  out  1  one-cycle shot strobe
- shot_x  out  12  x coordinate of the shot
- shot_y  out  12  y coordinate of the shot
- busy  out  1  high whenever the FSM is not in IDLE

Function
REQ-006 Every cycle with pos_valid=1, the block SHALL capture clamped coordinates into pending registers: min(xpos_in, H_MAX) and min(ypos_in, V_MAX), treating inputs as unsigned.
REQ-007 The block SHALL form frame_tick as a vblnk rising edge, i.e. vblnk=1 this cycle and vblnk=0 in the previous cycle.
REQ-008 On frame_tick, the block SHALL update xpos/ypos from the pending registers, so xpos/ypos change only once per frame.
REQ-009 When pos_valid coincides with frame_tick, xpos/ypos SHALL take the previous pending value, and the new sample SHALL take effect at the next frame_tick.
REQ-010 The block SHALL pass trigger through a 2-flop synchronizer, then a rising-edge detector on the synchronized signal.
REQ-011 With trigger high at clock edge 0 and the FSM in IDLE, shot SHALL be high for exactly one cycle starting after edge 2.
REQ-012 On that strobe, shot_x/shot_y SHALL hold the current xpos/ypos, and they SHALL hold that value until the next shot.
REQ-013 The FSM SHALL have the states IDLE, FLASH and COOLDOWN.
REQ-014 IDLE -> FLASH SHALL occur on a synchronized trigger edge, in the same cycle shot is registered, and the frame counter SHALL be cleared.
REQ-015 In FLASH, the frame counter SHALL increment on each frame_tick; after FLASH_FRAMES ticks the FSM SHALL go to COOLDOWN, or directly to IDLE if COOLDOWN_FRAMES=0, and the counter SHALL clear.
REQ-016 In COOLDOWN, the FSM SHALL return to IDLE after COOLDOWN_FRAMES frame_ticks.
REQ-017 A frame_tick in the same cycle as the IDLE->FLASH transition SHALL NOT be counted.
REQ-018 Trigger edges in FLASH or COOLDOWN SHALL be ignored and SHALL NOT produce shot.
REQ-019 A trigger held high continuously SHALL produce only one shot.
REQ-020 hide SHALL be registered, equal to gun_is_connected OR (state==FLASH) with one cycle of latency.
REQ-021 busy SHALL be registered, equal to (next state != IDLE), so it asserts in the same cycle as shot.

Reset
REQ-022 rst sampled high SHALL set xpos, ypos, shot_x, shot_y and the pending registers to 0, shot/hide/busy to 0, all synchronizer and edge flops to 0, the state to IDLE and the frame counter to 0.
REQ-023 A reset asserted mid-FLASH or mid-COOLDOWN SHALL abort the sequence, and no shot SHALL be produced for a trigger held through reset release unless it falls and rises again.

Configuration
REQ-024 The macro CROSSHAIR_SMOOTH_EN SHALL select how frame_tick updates xpos/ypos.
- Defined: xpos <= (xpos + pending_x) >> 1 and ypos <= (ypos + pending_y) >> 1, using a 13-bit sum truncated to 12 bits (a first-order smoothing filter).
- Undefined: xpos/ypos <= pending directly.
- All other behaviour SHALL be identical in both builds.

Verification
REQ-025 Clamp: xpos_in=900, ypos_in=700, pos_valid=1, then one vblnk rise -> xpos=799, ypos=599 (smoothing off).
REQ-026 Frame-stable: pos_valid samples x=100, then 200 mid-frame, no vblnk -> xpos unchanged; after vblnk rise -> xpos=200.
REQ-027 Shot: xpos=320, ypos=240, trigger rises -> shot=1 for one cycle 3 edges later, shot_x=320, shot_y=240, busy=1, and hide=1 on the following cycle.
REQ-028 Lockout: a second trigger pulse during FLASH and another during COOLDOWN -> no shot; busy stays high for exactly 3+10 frame_ticks, then IDLE and a new trigger produces a shot.
REQ-029 Reset mid-FLASH with trigger held high -> all outputs 0 and IDLE; no shot until trigger goes low then high.
REQ-030 CROSSHAIR_SMOOTH_EN defined: xpos=0, pending=400, two vblnk rises -> xpos=200 then 300.
